adc_ddr_tx: RTL and testbench
=============================

Name: adc_ddr_tx

Overview:
- Transmit-side counterpart of the AD9627 LVDS capture path. Accepts signed 12-bit two-channel sample pairs over a valid/ready stream and buffers them in an internal FIFO.
- Converts each sample to AD9627 offset-binary format and presents one rise word and one fall word per clock to downstream ODDR/OBUFDS primitives.
- Used for board loopback, ADC-emulation test benches, and driving DAC-style LVDS links.
- Supports a training preamble and AD9627-style test patterns (ramp, midscale, checkerboard).

Parameters:
- FIFO_DEPTH, 16, sample-pair FIFO depth; power of two, minimum 4.
- TRAIN_LEN, 64, number of clocks of training pattern after enable rises; minimum 1.

Ports:
- clk  in  1  design clock (clk_125m domain); all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  link enable; level-sensitive.
- pattern_sel  in  2  0=FIFO data, 1=ramp, 2=midscale, 3=checkerboard; sampled every cycle in RUN.
- clr_stats  in  1  synchronous clear of underflow_cnt.
- s_valid  in  1  input sample pair valid.
- s_ready  out  1  FIFO can accept a pair.
- s_data_a  in  12  signed two's-complement channel A sample.
- s_data_b  in  12  signed two's-complement channel B sample.
- tx_d_rise  out  12  offset-binary word for the rising edge (channel A); registered.
- tx_d_fall  out  12  offset-binary word for the falling edge (channel B); registered.
- tx_clk_en  out  1  forwarded-clock enable; registered.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- underflow_cnt  out  16  saturating count of RUN/pattern-0 cycles with an empty FIFO.
- link_state  out  2  0=IDLE, 1=TRAIN, 2=RUN.

Behaviour:
- Reset:
  - State IDLE; FIFO pointers and level cleared.
  - tx_d_rise=tx_d_fall=12'h800, tx_clk_en=0, s_ready=0, underflow_cnt=0.
  - Train counter and ramp counter cleared.
- Reset mid-operation discards all buffered data; no partial output.
- FIFO:
  - s_ready = enable && (fifo_level < FIFO_DEPTH).
  - s_ready does not anticipate a same-cycle pop: when full, one cycle of backpressure occurs even if a pop happens that cycle.
  - Push when s_valid && s_ready. Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - While enable=0 the FIFO is flushed (level forced to 0 each cycle).
- State machine:
  - IDLE: outputs 12'h800/12'h800, tx_clk_en=0. enable=1 → TRAIN; train counter loaded to 0.
  - TRAIN: tx_clk_en=1; rise=12'hAAA, fall=12'h555. Lasts exactly TRAIN_LEN cycles, then → RUN. The ramp counter is set to 0 on entry to RUN.
  - RUN: tx_clk_en=1. enable=0 in TRAIN or RUN → IDLE on the next edge, and outputs return to midscale on that edge.
- RUN output by pattern_sel:
  - 0, FIFO non-empty: pop one pair; rise = s_data_a + 12'h800 (MSB invert), fall = s_data_b + 12'h800.
  - 0, FIFO empty: rise=fall=12'h800; underflow_cnt increments, saturating at 16'hFFFF.
  - 1 (ramp): rise=ramp, fall=ramp+1, ramp += 2 each cycle, all modulo 4096. 12'hFFE/12'hFFF is followed by 12'h000/12'h001.
  - 2: rise=fall=12'h800.
  - 3: rise=12'hAAA, fall=12'h555.
  - Patterns 1–3 never pop the FIFO. FIFO fill continues during them.
- Latency: in RUN/pattern 0 with an empty FIFO, a pair handshaked on edge k appears on tx_d_* after edge k+1. The FIFO read is combinational from mem[rd_ptr]; the output is registered.
- underflow_cnt:
  - clr_stats has priority over increment: the count is 0 after the clear edge.
  - Not cleared by enable.

Test Plan:
- rst=1 for 3 cycles, then enable=0 → outputs 0x800/0x800, tx_clk_en=0, s_ready=0, link_state=0.
- enable↑ with TRAIN_LEN=64 → exactly 64 cycles of 0xAAA/0x555 with tx_clk_en=1, then link_state=2.
- RUN, pattern 0, push A=12'sh000,B=12'sh7FF, then A=-2048,B=-1 → outputs 0x800/0xFFF, then 0x000/0x7FF, each one cycle after handshake.
- RUN, pattern 0, s_valid held high for 20 cycles with no pops (pattern 2) → s_ready drops after 16 pushes, fifo_level=16. Switch to pattern 0 → data drains in order; 16 pairs out; then underflow_cnt increments 1 per cycle.
- Pattern 1 for 2050 cycles → rise/fall sequence 0/1, 2/3, …, 0xFFE/0xFFF, 0/1. FIFO level unchanged.
- Hold underflow for 70000 cycles → underflow_cnt=0xFFFF. clr_stats coinciding with an underflow cycle → 0. Drop enable → IDLE next edge, FIFO level 0.

Source files
------------

// File: rtl/adc_ddr_tx.sv
// AD9627-style LVDS transmit framer: buffers signed sample pairs, converts them to offset binary,
// and emits registered rise/fall words with a training preamble and built-in test patterns.
`timescale 1ns/1ps
module adc_ddr_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int TRAIN_LEN  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [1:0]                    pattern_sel,
    input  logic                          clr_stats,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [11:0]                   s_data_a,
    input  logic [11:0]                   s_data_b,
    output logic [11:0]                   tx_d_rise,
    output logic [11:0]                   tx_d_fall,
    output logic                          tx_clk_en,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underflow_cnt,
    output logic [1:0]                    link_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
    localparam logic [AW:0]   DEPTH_L    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);
    localparam logic [11:0]   MID        = 12'h800;
    localparam logic [11:0]   PAT_RISE   = 12'hAAA;
    localparam logic [11:0]   PAT_FALL   = 12'h555;

    typedef enum logic [1:0] {IDLE = 2'd0, TRAIN = 2'd1, RUN = 2'd2} state_t;

    state_t        state, state_nxt;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] train_cnt;
    logic [11:0]   ramp;
    logic          push, pop, fifo_empty, run_active;
    logic [11:0]   rise_nxt, fall_nxt;
    logic          clk_en_nxt;

    assign s_ready    = enable && (fifo_level < DEPTH_L);
    assign push       = s_valid && s_ready;
    assign fifo_empty = (fifo_level == '0);
    assign run_active = (state == RUN) && enable;
    assign pop        = run_active && (pattern_sel == 2'd0) && !fifo_empty;
    assign link_state = state;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = TRAIN; else state_nxt = IDLE;
            TRAIN:   if (!enable) state_nxt = IDLE;
                     else if (train_cnt == TRAIN_LAST) state_nxt = RUN;
                     else state_nxt = TRAIN;
            RUN:     if (!enable) state_nxt = IDLE; else state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Output word selection; the edge entering RUN emits midscale so the first RUN cycle is defined
    always_comb begin
        rise_nxt   = MID;
        fall_nxt   = MID;
        clk_en_nxt = 1'b0;
        case (state_nxt)
            TRAIN: begin
                rise_nxt   = PAT_RISE;
                fall_nxt   = PAT_FALL;
                clk_en_nxt = 1'b1;
            end
            RUN: begin
                clk_en_nxt = 1'b1;
                if (state == RUN) begin
                    case (pattern_sel)
                        2'd0: if (!fifo_empty) begin
                                  rise_nxt = mem[rd_ptr][23:12] + MID;
                                  fall_nxt = mem[rd_ptr][11:0] + MID;
                              end else begin
                                  rise_nxt = MID;
                                  fall_nxt = MID;
                              end
                        2'd1: begin
                            rise_nxt = ramp;
                            fall_nxt = ramp + 12'd1;
                        end
                        2'd3: begin
                            rise_nxt = PAT_RISE;
                            fall_nxt = PAT_FALL;
                        end
                        default: begin
                            rise_nxt = MID;
                            fall_nxt = MID;
                        end
                    endcase
                end else begin
                    rise_nxt = MID;
                    fall_nxt = MID;
                end
            end
            default: begin
                rise_nxt   = MID;
                fall_nxt   = MID;
                clk_en_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_d_rise <= MID;
            tx_d_fall <= MID;
            tx_clk_en <= 1'b0;
        end else begin
            tx_d_rise <= rise_nxt;
            tx_d_fall <= fall_nxt;
            tx_clk_en <= clk_en_nxt;
        end
    end

    // Training length and ramp generator counters
    always_ff @(posedge clk) begin
        if (rst) begin
            train_cnt <= '0;
            ramp      <= 12'd0;
        end else begin
            if (state == IDLE && enable) train_cnt <= '0;
            else if (state == TRAIN)     train_cnt <= train_cnt + TW'(1);
            if (state == TRAIN && state_nxt == RUN)    ramp <= 12'd0;
            else if (run_active && pattern_sel == 2'd1) ramp <= ramp + 12'd2;
        end
    end

    // FIFO storage; contents need no reset because the level gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_data_a, s_data_b};
    end

    // FIFO pointers and occupancy; a disabled link flushes the buffer
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Saturating underflow statistic; clear wins over a coincident increment
    always_ff @(posedge clk) begin
        if (rst)
            underflow_cnt <= 16'd0;
        else if (clr_stats)
            underflow_cnt <= 16'd0;
        else if (run_active && pattern_sel == 2'd0 && fifo_empty && underflow_cnt != 16'hFFFF)
            underflow_cnt <= underflow_cnt + 16'd1;
    end
endmodule

// File: tb/tb_adc_ddr_tx.sv
// Scenario bench for adc_ddr_tx: a queue of expected offset-binary pairs is filled on every
// handshake and drained whenever the link should emit FIFO data.
`timescale 1ns/1ps
module tb_adc_ddr_tx;
    logic        clk = 1'b0;
    logic        rst, enable, clr_stats, s_valid, s_ready, tx_clk_en;
    logic [1:0]  pattern_sel, link_state;
    logic [11:0] s_data_a, s_data_b, tx_d_rise, tx_d_fall;
    logic [4:0]  fifo_level;
    logic [15:0] underflow_cnt;

    int          total = 0;
    int          bad = 0;
    logic [23:0] m_q[$];
    logic [11:0] m_ramp;
    logic [15:0] m_ucnt;

    adc_ddr_tx #(.FIFO_DEPTH(16), .TRAIN_LEN(64)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .clr_stats(clr_stats), .s_valid(s_valid), .s_ready(s_ready),
        .s_data_a(s_data_a), .s_data_b(s_data_b), .tx_d_rise(tx_d_rise),
        .tx_d_fall(tx_d_fall), .tx_clk_en(tx_clk_en), .fifo_level(fifo_level),
        .underflow_cnt(underflow_cnt), .link_state(link_state)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One RUN-state clock: predict handshake, output word and stats, then compare after the edge
    task automatic step();
        logic        exp_rdy;
        logic [23:0] e;
        logic [11:0] er, ef;
        @(negedge clk);
        exp_rdy = (m_q.size() < 16);
        total++;
        if (s_ready !== exp_rdy) begin
            bad++;
            $display("FAIL s_ready: got %0b want %0b", s_ready, exp_rdy);
        end
        er = 12'h800;
        ef = 12'h800;
        case (pattern_sel)
            2'd0: if (m_q.size() > 0) begin
                      e  = m_q.pop_front();
                      er = e[23:12];
                      ef = e[11:0];
                  end else if (m_ucnt != 16'hFFFF) begin
                      m_ucnt = m_ucnt + 16'd1;
                  end
            2'd1: begin
                er     = m_ramp;
                ef     = m_ramp + 12'd1;
                m_ramp = m_ramp + 12'd2;
            end
            2'd3: begin
                er = 12'hAAA;
                ef = 12'h555;
            end
            default: ;
        endcase
        if (clr_stats) m_ucnt = 16'd0;
        if (s_valid && exp_rdy) m_q.push_back({s_data_a ^ 12'h800, s_data_b ^ 12'h800});
        cyc();
        total++;
        if (tx_d_rise !== er) begin bad++; $display("FAIL rise: got %h want %h", tx_d_rise, er); end
        total++;
        if (tx_d_fall !== ef) begin bad++; $display("FAIL fall: got %h want %h", tx_d_fall, ef); end
        total++;
        if (fifo_level !== 5'(m_q.size())) begin
            bad++; $display("FAIL level: got %0d want %0d", fifo_level, m_q.size());
        end
        total++;
        if (underflow_cnt !== m_ucnt) begin
            bad++; $display("FAIL ucnt: got %h want %h", underflow_cnt, m_ucnt);
        end
        total++;
        if (link_state !== 2'd2 || tx_clk_en !== 1'b1) begin
            bad++; $display("FAIL run_state: got state %0d clk_en %0b want 2 1", link_state, tx_clk_en);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0; clr_stats = 1'b0;
        s_valid = 1'b0; s_data_a = 12'h000; s_data_b = 12'h000;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        total++;
        if (tx_d_rise !== 12'h800 || tx_d_fall !== 12'h800) begin
            bad++; $display("FAIL reset_words: got %h/%h want 800/800", tx_d_rise, tx_d_fall);
        end
        total++;
        if (tx_clk_en !== 1'b0 || s_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: got clk_en %0b ready %0b want 0 0", tx_clk_en, s_ready);
        end
        total++;
        if (link_state !== 2'd0 || fifo_level !== 5'd0 || underflow_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_state: got %0d/%0d/%0d want 0/0/0", link_state, fifo_level, underflow_cnt);
        end
        m_ucnt = 16'd0;
    endtask

    task automatic test_train();
        int n_train = 0;
        pattern_sel = 2'd2;
        enable = 1'b1;
        for (int i = 0; i < 64; i++) begin
            cyc();
            if (link_state == 2'd1 && tx_d_rise == 12'hAAA && tx_d_fall == 12'h555 && tx_clk_en == 1'b1)
                n_train++;
        end
        total++;
        if (n_train !== 64) begin bad++; $display("FAIL train_len: got %0d want 64", n_train); end
        cyc();
        total++;
        if (link_state !== 2'd2 || tx_d_rise !== 12'h800 || tx_clk_en !== 1'b1) begin
            bad++; $display("FAIL run_entry: got state %0d rise %h want 2 800", link_state, tx_d_rise);
        end
        m_ramp = 12'd0;
    endtask

    task automatic test_latency();
        pattern_sel = 2'd0;
        s_valid = 1'b1; s_data_a = 12'h000; s_data_b = 12'h7FF;
        step();
        s_data_a = 12'h800; s_data_b = 12'hFFF;
        step();
        s_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_fill_drain();
        pattern_sel = 2'd2;
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data_a = 12'(i * 181 + 7);
            s_data_b = 12'(i * 533 + 1000);
            step();
        end
        total++;
        if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_level: got %0d want 16", fifo_level); end
        s_valid = 1'b0;
        pattern_sel = 2'd0;
        repeat (21) step();
    endtask

    task automatic test_ramp();
        s_valid = 1'b1; s_data_a = 12'h123; s_data_b = 12'h456;
        pattern_sel = 2'd1;
        step();
        s_valid = 1'b0;
        repeat (2050) step();
    endtask

    task automatic test_underflow_sat();
        pattern_sel = 2'd0;
        repeat (70000) step();
        total++;
        if (underflow_cnt !== 16'hFFFF) begin
            bad++; $display("FAIL ucnt_sat: got %h want ffff", underflow_cnt);
        end
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        repeat (3) step();
        pattern_sel = 2'd3;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data_a = 12'(i + 40);
            s_data_b = 12'(i + 80);
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic test_disable();
        enable = 1'b0;
        cyc();
        total++;
        if (link_state !== 2'd0 || tx_clk_en !== 1'b0) begin
            bad++; $display("FAIL disable_state: got %0d clk_en %0b want 0 0", link_state, tx_clk_en);
        end
        total++;
        if (tx_d_rise !== 12'h800 || tx_d_fall !== 12'h800) begin
            bad++; $display("FAIL disable_words: got %h/%h want 800/800", tx_d_rise, tx_d_fall);
        end
        total++;
        if (fifo_level !== 5'd0 || s_ready !== 1'b0) begin
            bad++; $display("FAIL flush: got level %0d ready %0b want 0 0", fifo_level, s_ready);
        end
        total++;
        if (underflow_cnt !== 16'd3) begin
            bad++; $display("FAIL ucnt_hold: got %0d want 3", underflow_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_train();
        test_latency();
        test_fill_drain();
        test_ramp();
        test_underflow_sat();
        test_disable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
